cpu_datapath: RTL and testbench
===============================

// Module: cpu_datapath
// PURPOSE
//  Datapath/memory responder driven by the 7-signal sequence controller (memrd, loadir, halt,
//  incpc, loadac, loadpc, memwr); returns opcode and zero to it. Holds PC, IR, AC, ALU and a
//  2^ADDR_W x DATA_W memory. Runs in lockstep with the controller's 8-phase instruction cycle;
//  a preload port fills memory before a run.
// PARAMETERS
//  DATA_W  8  word width; IR = {opcode[2:0], address[ADDR_W-1:0]}, so DATA_W = 3+ADDR_W
//  ADDR_W  5  memory address width (32 words)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  memrd      in   1       controller: memory read enable (informational, checked)
//  loadir     in   1       controller: IR <= mem[addr]
//  halt       in   1       controller: stop execution
//  incpc      in   1       controller: PC <= PC+1
//  loadac     in   1       controller: AC <= ALU result
//  loadpc     in   1       controller: PC <= IR address field
//  memwr      in   1       controller: mem[addr] <= AC
//  prog_en    in   1       preload mode; freezes execution
//  prog_we    in   1       preload write strobe (only when prog_en=1)
//  prog_addr  in   ADDR_W  preload address
//  prog_data  in   DATA_W  preload data
//  opcode     out  3       IR[DATA_W-1:DATA_W-3] to controller
//  zero       out  1       (AC == 0), combinational
//  pc_out     out  ADDR_W  current PC
//  ac_out     out  DATA_W  current AC
//  halted     out  1       sticky halt status
//  proto_err  out  1       sticky protocol-violation flag
// BEHAVIOUR
//  - Reset (async): PC=0, IR=0, AC=0, ph=0, halted=0, proto_err=0 -> opcode=0, zero=1.
//    Memory contents not reset. Reset mid-instruction aborts it; execution restarts at PC 0.
//  - Phase counter ph (3b): +1 per clk, 7->0 wrap; held when prog_en=1 or halted=1.
//  - addr = (ph<4) ? PC : IR[ADDR_W-1:0]; mdata = mem[addr], combinational read.
//  - Register updates on rising clk, only when prog_en=0 and halted=0:
//    loadir: IR <= mdata.  loadpc: PC <= IR addr.  incpc: PC <= PC+1 mod 2^ADDR_W (31->0).
//    loadpc and incpc same cycle: loadpc wins.  memwr: mem[addr] <= AC.
//    loadac: AC <= per opcode: 010 ADD AC+mdata mod 2^DATA_W (carry dropped); 011 AND;
//    100 XOR; 101 LDA mdata; 000/001/110/111: AC unchanged.
//  - halt=1 at edge: halted <= 1, sticky until rst; same-edge updates other than halted suppressed.
//  - prog_en=1: ph held at 0, controller inputs ignored (no error checks);
//    prog_we=1 writes mem[prog_addr] <= prog_data at edge. prog_we ignored when prog_en=0.
//  - proto_err <= 1 (sticky, checked only when prog_en=0, halted=0) on: memrd&memwr;
//    loadir with ph>=4; memwr with ph<4. The offending operation still executes.
// TESTING
//  1 rst=1 mid-run -> PC=0, AC=0, IR=0, ph=0, zero=1, halted=0, proto_err=0 immediately (async).
//  2 preload mem[0]=8'hA3 (LDA 3), mem[3]=8'h05; drive LDA sequence -> IR=A3, opcode=101,
//    AC=05, zero=0, PC=1.
//  3 AC=8'hFF, mem[4]=8'h01, ADD 4 -> AC=00, zero=1 (carry dropped); STO 5 -> mem[5]=00.
//  4 PC=31, incpc -> PC=0; same edge loadpc+incpc with IR addr=9 -> PC=9.
//  5 memrd=memwr=1 in ph 2 -> proto_err=1, stays 1 until rst; loadir at ph 5 also flags.
//  6 halt=1 -> halted=1; further incpc/loadac produce no change to PC/AC/ph until rst.

Source files
------------

// File: rtl/cpu_datapath.sv
// cpu_datapath
//   Datapath and memory responder for an 8-phase sequence controller. It holds
//   the PC, IR and AC registers, the ALU, and a 2^ADDR_W x DATA_W memory. It
//   also has a preload port that fills memory before a run.
//
// Ports
//   clk, rst                    rising-edge clock; asynchronous active-high reset
//   memrd, loadir, halt, incpc,
//   loadac, loadpc, memwr       per-phase strobes from the controller
//   prog_en, prog_we,
//   prog_addr, prog_data        preload port; prog_en also freezes execution
//   opcode, zero                decode feedback to the controller
//   pc_out, ac_out              current PC and accumulator
//   halted, proto_err           sticky status flags, cleared only by rst
module cpu_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memrd,
    input  logic              loadir,
    input  logic              halt,
    input  logic              incpc,
    input  logic              loadac,
    input  logic              loadpc,
    input  logic              memwr,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [2:0]        opcode,
    output logic              zero,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] ac_out,
    output logic              halted,
    output logic              proto_err
);

    localparam int MEM_DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic [2:0]        ph_q, ph_d;
    logic              halted_q, halted_d;
    logic              proto_err_q, proto_err_d;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mdata;
    logic [DATA_W-1:0] alu_res;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign ir_addr = ir_q[ADDR_W-1:0];
    assign opcode  = ir_q[DATA_W-1 -: 3];

    // Phases 0-3 fetch from the PC; phases 4-7 access the IR operand address.
    assign addr  = ph_q[2] ? ir_addr : pc_q;
    assign mdata = mem_q[addr];

    always_comb begin
        case (opcode)
            3'b010:  alu_res = ac_q + mdata;
            3'b011:  alu_res = ac_q & mdata;
            3'b100:  alu_res = ac_q ^ mdata;
            3'b101:  alu_res = mdata;
            default: alu_res = ac_q;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        ac_d        = ac_q;
        ph_d        = ph_q;
        halted_d    = halted_q;
        proto_err_d = proto_err_q;
        mem_we      = 1'b0;
        mem_waddr   = addr;
        mem_wdata   = ac_q;

        if (prog_en) begin
            ph_d = 3'd0;
            if (prog_we) begin
                mem_we    = 1'b1;
                mem_waddr = prog_addr;
                mem_wdata = prog_data;
            end
        end else if (!halted_q) begin
            if (halt) begin
                // A halt edge freezes everything else on that same edge.
                halted_d = 1'b1;
            end else begin
                ph_d = ph_q + 3'd1;
                if (loadir) ir_d = mdata;
                if (loadpc) pc_d = ir_addr;
                else if (incpc) pc_d = pc_q + ADDR_W'(1);
                if (loadac) ac_d = alu_res;
                if (memwr) mem_we = 1'b1;
                // Protocol violations are flagged, but the operation still executes.
                if ((memrd && memwr) || (loadir && ph_q[2]) || (memwr && !ph_q[2]))
                    proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            ir_q        <= '0;
            ac_q        <= '0;
            ph_q        <= '0;
            halted_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ac_q        <= ac_d;
            ph_q        <= ph_d;
            halted_q    <= halted_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Memory is intentionally not reset, so preloaded programs survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign zero      = (ac_q == '0);
    assign pc_out    = pc_q;
    assign ac_out    = ac_q;
    assign halted    = halted_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       memrd = 1'b0, loadir = 1'b0, halt = 1'b0, incpc = 1'b0;
    logic       loadac = 1'b0, loadpc = 1'b0, memwr = 1'b0;
    logic       prog_en = 1'b0, prog_we = 1'b0;
    logic [4:0] prog_addr = '0;
    logic [7:0] prog_data = '0;
    logic [2:0] opcode;
    logic       zero;
    logic [4:0] pc_out;
    logic [7:0] ac_out;
    logic       halted;
    logic       proto_err;

    cpu_datapath #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .memrd(memrd), .loadir(loadir), .halt(halt), .incpc(incpc),
        .loadac(loadac), .loadpc(loadpc), .memwr(memwr),
        .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .opcode(opcode), .zero(zero), .pc_out(pc_out), .ac_out(ac_out),
        .halted(halted), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Strobe encodings for step(): {memrd, loadir, halt, incpc, loadac, loadpc, memwr}
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_RD   = 7'b1000000;
    localparam logic [6:0] S_IR   = 7'b0100000;
    localparam logic [6:0] S_HL   = 7'b0010000;
    localparam logic [6:0] S_INC  = 7'b0001000;
    localparam logic [6:0] S_LAC  = 7'b0000100;
    localparam logic [6:0] S_LPC  = 7'b0000010;
    localparam logic [6:0] S_WR   = 7'b0000001;

    typedef struct packed {
        logic [4:0] pc;
        logic [7:0] ac;
        logic [2:0] op;
        logic       z;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] mem_m [32];
    logic [4:0] pc_m;
    logic [7:0] ac_m;
    logic [7:0] ir_m;

    task automatic step(input logic [6:0] v);
        {memrd, loadir, halt, incpc, loadac, loadpc, memwr} = v;
        @(posedge clk);
        #1;
        {memrd, loadir, halt, incpc, loadac, loadpc, memwr} = S_NONE;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        pc_m = '0;
        ac_m = '0;
        ir_m = '0;
    endtask

    task automatic preload(input logic [4:0] a, input logic [7:0] d);
        prog_en   = 1'b1;
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(posedge clk);
        #1;
        prog_we  = 1'b0;
        prog_en  = 1'b0;
        mem_m[a] = d;
    endtask

    // Drives one full controller instruction cycle; the model's expectation is
    // queued before the phases are driven and compared once they complete.
    task automatic run_instr;
        exp_t       e;
        logic [2:0] op;
        logic [4:0] a;
        logic       alu, jmp, sto;
        ir_m = mem_m[pc_m];
        op   = ir_m[7:5];
        a    = ir_m[4:0];
        pc_m = pc_m + 5'd1;
        case (op)
            3'b010:  ac_m = ac_m + mem_m[a];
            3'b011:  ac_m = ac_m & mem_m[a];
            3'b100:  ac_m = ac_m ^ mem_m[a];
            3'b101:  ac_m = mem_m[a];
            3'b110:  mem_m[a] = ac_m;
            3'b111:  pc_m = a;
            default: ;
        endcase
        e.pc = pc_m;
        e.ac = ac_m;
        e.op = op;
        e.z  = (ac_m == 8'h00);
        sb_q.push_back(e);
        sto = (op == 3'b110);
        jmp = (op == 3'b111);
        alu = !sto && !jmp;
        step(S_NONE);
        step(S_RD);
        step(S_RD | S_IR);
        step(S_RD | S_IR);
        step(S_INC);
        step(alu ? S_RD : S_NONE);
        step((alu ? S_RD : S_NONE) | (jmp ? S_LPC : S_NONE));
        step((alu ? (S_RD | S_LAC) : S_NONE) | (jmp ? S_LPC : S_NONE) | (sto ? S_WR : S_NONE));
        e = sb_q.pop_front();
        checks++; if (pc_out !== e.pc) begin errors++; $display("FAIL instr_pc: got %h want %h", pc_out, e.pc); end
        checks++; if (ac_out !== e.ac) begin errors++; $display("FAIL instr_ac: got %h want %h", ac_out, e.ac); end
        checks++; if (opcode !== e.op) begin errors++; $display("FAIL instr_opcode: got %b want %b", opcode, e.op); end
        checks++; if (zero !== e.z) begin errors++; $display("FAIL instr_zero: got %b want %b", zero, e.z); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL instr_proto: got %b want 0", proto_err); end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #2;
        checks++; if (pc_out !== 5'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc_out); end
        checks++; if (ac_out !== 8'd0) begin errors++; $display("FAIL reset_ac: got %h want 0", ac_out); end
        checks++; if (opcode !== 3'd0) begin errors++; $display("FAIL reset_opcode: got %b want 0", opcode); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto: got %b want 0", proto_err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lda;
        do_reset();
        preload(5'd0, 8'hA3);
        preload(5'd3, 8'h05);
        run_instr();
    endtask

    // LDA 20, ADD 4 (FF+01 -> 00), STO 5, JMP 24, LDA 20, LDA 5, XOR 28, AND 29
    task automatic test_alu_sto;
        do_reset();
        preload(5'd0,  8'hB4);
        preload(5'd1,  8'h44);
        preload(5'd2,  8'hC5);
        preload(5'd3,  8'hF8);
        preload(5'd4,  8'h01);
        preload(5'd5,  8'h77);
        preload(5'd20, 8'hFF);
        preload(5'd24, 8'hB4);
        preload(5'd25, 8'hA5);
        preload(5'd26, 8'h9C);
        preload(5'd27, 8'h7D);
        preload(5'd28, 8'h3C);
        preload(5'd29, 8'h0F);
        for (int i = 0; i < 8; i++) run_instr();
    endtask

    task automatic test_pc_wrap;
        do_reset();
        preload(5'd0,  8'hFF);
        preload(5'd31, 8'hE9);
        step(S_NONE); step(S_RD); step(S_RD | S_IR); step(S_RD);
        step(S_NONE); step(S_NONE); step(S_LPC);
        checks++; if (pc_out !== 5'd31) begin errors++; $display("FAIL pc_load31: got %0d want 31", pc_out); end
        step(S_NONE);
        step(S_NONE); step(S_RD); step(S_RD | S_IR);
        checks++; if (opcode !== 3'b111) begin errors++; $display("FAIL pc_ir_op: got %b want 111", opcode); end
        step(S_RD);
        step(S_INC);
        checks++; if (pc_out !== 5'd0) begin errors++; $display("FAIL pc_wrap: got %0d want 0", pc_out); end
        step(S_NONE);
        step(S_LPC | S_INC);
        checks++; if (pc_out !== 5'd9) begin errors++; $display("FAIL pc_loadpc_wins: got %0d want 9", pc_out); end
        step(S_NONE);
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL pc_proto_clean: got %b want 0", proto_err); end
    endtask

    task automatic test_proto_err;
        do_reset();
        step(S_NONE); step(S_RD);
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_pre: got %b want 0", proto_err); end
        step(S_RD | S_WR);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_rdwr: got %b want 1", proto_err); end
        for (int i = 0; i < 4; i++) step(S_NONE);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b want 1", proto_err); end
        do_reset();
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_cleared: got %b want 0", proto_err); end
        for (int i = 0; i < 5; i++) step(S_NONE);
        step(S_IR);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_loadir_ph5: got %b want 1", proto_err); end
        do_reset();
        step(S_WR);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_memwr_ph0: got %b want 1", proto_err); end
        mem_m[0] = 8'h00;
        do_reset();
    endtask

    task automatic test_halt;
        do_reset();
        preload(5'd0, 8'hA3);
        preload(5'd3, 8'h05);
        step(S_NONE); step(S_RD); step(S_RD | S_IR); step(S_RD | S_IR);
        step(S_HL | S_INC);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", halted); end
        checks++; if (pc_out !== 5'd0) begin errors++; $display("FAIL halt_same_edge_pc: got %0d want 0", pc_out); end
        for (int i = 0; i < 3; i++) step(S_RD | S_INC | S_LAC | S_LPC);
        step(S_RD | S_WR);
        checks++; if (pc_out !== 5'd0) begin errors++; $display("FAIL halt_pc_frozen: got %0d want 0", pc_out); end
        checks++; if (ac_out !== 8'h00) begin errors++; $display("FAIL halt_ac_frozen: got %h want 00", ac_out); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b want 1", halted); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL halt_no_proto: got %b want 0", proto_err); end
        do_reset();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_cleared: got %b want 0", halted); end
    endtask

    task automatic test_async_reset;
        do_reset();
        preload(5'd0, 8'hA3);
        preload(5'd3, 8'h05);
        run_instr();
        step(S_NONE);
        step(S_RD | S_WR);
        mem_m[1] = 8'h05;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL async_pre_proto: got %b want 1", proto_err); end
        step(S_RD | S_IR);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pc_out !== 5'd0) begin errors++; $display("FAIL async_pc: got %h want 0", pc_out); end
        checks++; if (ac_out !== 8'd0) begin errors++; $display("FAIL async_ac: got %h want 0", ac_out); end
        checks++; if (opcode !== 3'd0) begin errors++; $display("FAIL async_opcode: got %b want 0", opcode); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL async_zero: got %b want 1", zero); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL async_proto: got %b want 0", proto_err); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL async_halted: got %b want 0", halted); end
        @(negedge clk);
        rst  = 1'b0;
        pc_m = '0;
        ac_m = '0;
        run_instr();
        run_instr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lda();
        test_alu_sto();
        test_pc_wrap();
        test_proto_err();
        test_halt();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
